// File: rtl/seq_event_counter.sv
// seq_event_counter: counts completed sequences reported by an upstream
// detector (prog == 111), flags illegal progress codes, and raises an
// alert when THRESH matches fall inside one WIN-cycle observation window.

module seq_event_counter #(
    parameter int CNT_W  = 8,
    parameter int WIN    = 16,
    parameter int THRESH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [2:0]       prog,
    input  logic             clr,
    input  logic             ack,
    output logic [CNT_W-1:0] match_cnt,
    output logic             irq,
    output logic             ovf,
    output logic             prog_err
);

    // The window counter counts down from WIN-1; the tally only needs to reach THRESH.
    localparam int WCNT_W = (WIN > 1) ? $clog2(WIN) : 1;
    localparam int WM_W   = $clog2(THRESH + 1);

    localparam logic [WCNT_W-1:0] WIN_LAST = WCNT_W'(WIN - 1);
    localparam logic [WM_W-1:0]   THRESH_V = WM_W'(THRESH);
    localparam logic [CNT_W-1:0]  CNT_MAX  = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        WINDOW,
        ALERT
    } state_t;

    state_t            state;
    state_t            state_n;
    logic [WCNT_W-1:0] wcnt;
    logic [WCNT_W-1:0] wcnt_n;
    logic [WM_W-1:0]   wm;
    logic [WM_W-1:0]   wm_n;
    logic [WM_W-1:0]   wm_sum;
    logic [2:0]        prev_prog;
    logic              match;
    logic              err;

    // A match is the rising edge into the "complete" code, only while enabled.
    assign match  = en && (prog == 3'b111) && (prev_prog != 3'b111);
    assign wm_sum = wm + WM_W'(match);
    assign irq    = (state == ALERT);

    // Legal progress only walks 000 -> 001 -> 011 -> 111; anything else is an error.
    always_comb begin
        err = 1'b0;
        case (prog)
            3'b010, 3'b100, 3'b101, 3'b110: err = 1'b1;
            3'b011:  err = !((prev_prog == 3'b001) || (prev_prog == 3'b011));
            3'b111:  err = (prev_prog != 3'b011);
            default: err = 1'b0;
        endcase
    end

    // Previous progress code is tracked every cycle, even when counting is disabled.
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_prog <= 3'b000;
        end else begin
            prev_prog <= prog;
        end
    end

    // Saturating match counter and sticky status flags; clear beats a same-cycle event.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            match_cnt <= '0;
            ovf       <= 1'b0;
            prog_err  <= 1'b0;
        end else begin
            if (match) begin
                if (match_cnt == CNT_MAX) begin
                    ovf <= 1'b1;
                end else begin
                    match_cnt <= match_cnt + CNT_W'(1);
                end
            end
            if (err) begin
                prog_err <= 1'b1;
            end
        end
    end

    // Window FSM state, down-counter and tally registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            wcnt  <= '0;
            wm    <= '0;
        end else begin
            state <= state_n;
            wcnt  <= wcnt_n;
            wm    <= wm_n;
        end
    end

    // Window FSM next state: disable wins over everything, then threshold, then expiry.
    always_comb begin
        state_n = state;
        wcnt_n  = wcnt;
        wm_n    = wm;
        case (state)
            IDLE: begin
                wcnt_n = '0;
                wm_n   = '0;
                if (en) begin
                    state_n = WINDOW;
                    wcnt_n  = WIN_LAST;
                end
            end
            WINDOW: begin
                if (!en) begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                    wm_n    = '0;
                end else if (wm_sum == THRESH_V) begin
                    state_n = ALERT;
                    wm_n    = wm_sum;
                end else if (wcnt == '0) begin
                    wcnt_n = WIN_LAST;
                    wm_n   = '0;
                end else begin
                    wcnt_n = wcnt - WCNT_W'(1);
                    wm_n   = wm_sum;
                end
            end
            ALERT: begin
                if (!en) begin
                    state_n = IDLE;
                    wcnt_n  = '0;
                    wm_n    = '0;
                end else if (ack) begin
                    state_n = WINDOW;
                    wcnt_n  = WIN_LAST;
                    wm_n    = '0;
                end
            end
            default: begin
                state_n = IDLE;
                wcnt_n  = '0;
                wm_n    = '0;
            end
        endcase
    end

endmodule

// File: tb/tb_seq_event_counter.sv
// tb_seq_event_counter: directed scenarios followed by random traffic, all
// compared against a cycle-level behavioural model of the counter.

module tb_seq_event_counter;

    localparam int CNT_W  = 3;
    localparam int WIN    = 8;
    localparam int THRESH = 2;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             en = 1'b0;
    logic [2:0]       prog = 3'b000;
    logic             clr = 1'b0;
    logic             ack = 1'b0;
    logic [CNT_W-1:0] match_cnt;
    logic             irq;
    logic             ovf;
    logic             prog_err;

    int errors = 0;
    int checks = 0;

    // Behavioural model: counts, flags, and a window described by position and hit tally.
    int m_cnt     = 0;
    bit m_ovf     = 0;
    bit m_err     = 0;
    int m_prev    = 0;
    bit m_active  = 0;
    bit m_alert   = 0;
    int m_pos     = 0;
    int m_hits    = 0;

    seq_event_counter #(
        .CNT_W (CNT_W),
        .WIN   (WIN),
        .THRESH(THRESH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .prog     (prog),
        .clr      (clr),
        .ack      (ack),
        .match_cnt(match_cnt),
        .irq      (irq),
        .ovf      (ovf),
        .prog_err (prog_err)
    );

    always #5 clk = ~clk;

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic modelEdge();
        bit mt;
        bit er;
        int p;
        p = int'(prog);
        if (rst) begin
            m_cnt = 0; m_ovf = 0; m_err = 0; m_prev = 0;
            m_active = 0; m_alert = 0; m_pos = 0; m_hits = 0;
            return;
        end
        mt = en && (p == 7) && (m_prev != 7);
        er = (p == 2) || (p == 4) || (p == 5) || (p == 6) ||
             ((p == 3) && !((m_prev == 1) || (m_prev == 3))) ||
             ((p == 7) && (m_prev != 3));
        if (clr) begin
            m_cnt = 0; m_ovf = 0; m_err = 0;
        end else begin
            if (mt) begin
                if (m_cnt == (1 << CNT_W) - 1) m_ovf = 1;
                else m_cnt++;
            end
            if (er) m_err = 1;
        end
        if (!en) begin
            m_active = 0; m_alert = 0; m_pos = 0; m_hits = 0;
        end else if (!m_active) begin
            m_active = 1; m_pos = 0; m_hits = 0;
        end else if (m_alert) begin
            if (ack) begin
                m_alert = 0; m_pos = 0; m_hits = 0;
            end
        end else begin
            m_hits += int'(mt);
            if (m_hits >= THRESH) m_alert = 1;
            else if (m_pos == WIN - 1) begin
                m_pos = 0; m_hits = 0;
            end else m_pos++;
        end
        m_prev = p;
    endtask

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    // Apply one cycle of inputs, clock it, then compare all outputs with the model.
    task automatic applyStimulus(input bit r, input bit e, input int p, input bit c, input bit a);
        rst = r; en = e; prog = 3'(p); clr = c; ack = a;
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput("match_cnt", int'(match_cnt), m_cnt);
        checkOutput("irq", int'(irq), int'(m_alert));
        checkOutput("ovf", int'(ovf), int'(m_ovf));
        checkOutput("prog_err", int'(prog_err), int'(m_err));
    endtask

    task automatic doReset();
        applyStimulus(1, 0, 0, 0, 0);
    endtask

    initial begin
        int seq[$];
        int legal[4];
        legal[0] = 0; legal[1] = 1; legal[2] = 3; legal[3] = 7;
        $display("[TB] start");

        // Reset state
        doReset();
        checkOutput("reset_cnt", int'(match_cnt), 0);
        checkOutput("reset_irq", int'(irq), 0);

        // Basic count, then a second sequence raises the alert
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 3, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        checkOutput("basic_cnt", int'(match_cnt), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("basic_irq", int'(irq), 0);
        checkOutput("basic_err", int'(prog_err), 0);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 3, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        checkOutput("alert_irq", int'(irq), 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("alert_hold", int'(irq), 1);
        applyStimulus(0, 1, 0, 0, 1);
        checkOutput("alert_ack", int'(irq), 0);
        checkOutput("alert_cnt", int'(match_cnt), 2);

        // Window expiry: matches in window cycles 2 and 10
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        seq = '{1, 3, 7, 0, 0, 0, 0, 0, 1, 3, 7, 0};
        foreach (seq[i]) applyStimulus(0, 1, seq[i], 0, 0);
        checkOutput("expiry_irq", int'(irq), 0);
        checkOutput("expiry_cnt", int'(match_cnt), 2);

        // Saturation and clear priority
        doReset();
        for (int k = 0; k < 8; k++) begin
            applyStimulus(0, 1, 1, 0, 0);
            applyStimulus(0, 1, 3, 0, 0);
            applyStimulus(0, 1, 7, 0, 0);
        end
        checkOutput("sat_cnt", int'(match_cnt), 7);
        checkOutput("sat_ovf", int'(ovf), 1);
        applyStimulus(0, 1, 1, 0, 0);
        applyStimulus(0, 1, 3, 0, 0);
        applyStimulus(0, 1, 7, 1, 0);
        checkOutput("clr_cnt", int'(match_cnt), 0);
        checkOutput("clr_ovf", int'(ovf), 0);

        // Error flags are sticky until cleared
        doReset();
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 7, 0, 0);
        checkOutput("err_jump", int'(prog_err), 1);
        checkOutput("err_jump_cnt", int'(match_cnt), 1);
        applyStimulus(0, 1, 0, 0, 0);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("err_sticky", int'(prog_err), 1);
        applyStimulus(0, 1, 0, 1, 0);
        checkOutput("err_clr", int'(prog_err), 0);
        applyStimulus(0, 1, 6, 0, 0);
        checkOutput("err_code", int'(prog_err), 1);
        applyStimulus(0, 1, 0, 0, 0);
        checkOutput("err_code_sticky", int'(prog_err), 1);

        // Reset during alert, and disable beating ack in alert
        doReset();
        seq = '{0, 1, 3, 7, 1, 3, 7};
        foreach (seq[i]) applyStimulus(0, 1, seq[i], 0, 0);
        checkOutput("pre_rst_irq", int'(irq), 1);
        applyStimulus(1, 1, 0, 0, 0);
        checkOutput("rst_irq", int'(irq), 0);
        checkOutput("rst_cnt", int'(match_cnt), 0);
        foreach (seq[i]) applyStimulus(0, 1, seq[i], 0, 0);
        checkOutput("pre_dis_irq", int'(irq), 1);
        applyStimulus(0, 0, 0, 0, 1);
        checkOutput("dis_irq", int'(irq), 0);
        applyStimulus(0, 1, 0, 0, 0);

        // Random traffic against the model
        doReset();
        for (int k = 0; k < 600; k++) begin
            int p;
            if ($urandom_range(0, 9) == 0) p = int'($urandom_range(0, 7));
            else p = legal[$urandom_range(0, 3)];
            applyStimulus($urandom_range(0, 99) == 0,
                          $urandom_range(0, 15) != 0,
                          p,
                          $urandom_range(0, 39) == 0,
                          $urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
